// File: rtl/tag_mem_pkg.sv
// tag_mem_pkg: command encodings, sequencer states and channel-width helper for tag_mem_seq.
package tag_mem_pkg;
  typedef enum logic [1:0] {
    OP_EPC_READ    = 2'b00,
    OP_EPC_WRITE   = 2'b01,
    OP_SENSOR_READ = 2'b10,
    OP_RSV         = 2'b11
  } op_t;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACC, S_REL, S_STREAM} state_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tag_tx_shifter.sv
// tag_tx_shifter: one-word prefetch buffer feeding an LSB-first serial shifter.
module tag_tx_shifter #(
  parameter int WORD_W = 16
) (
  input  logic              data_clk,
  input  logic              factory_reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  output logic              empty,
  output logic              last,
  output logic              tx_bit,
  output logic              tx_valid
);
  localparam int CW = $clog2(WORD_W);
  logic [WORD_W-1:0] buf_q, sh;
  logic [CW-1:0] cnt;
  logic full, take;
  assign empty = !full;
  assign last = tx_valid && cnt == CW'(WORD_W - 1);
  assign take = full && (!tx_valid || last);
  assign tx_bit = sh[0];
  // Reload on the last bit keeps the stream gap-free; an idle shifter drains to zero.
  always_ff @(posedge data_clk or posedge factory_reset) begin
    if (factory_reset) begin
      buf_q <= '0;
      sh <= '0;
      cnt <= '0;
      full <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      full <= load ? 1'b1 : take ? 1'b0 : full;
      if (load) buf_q <= load_data;
      if (take) begin
        sh <= buf_q;
        cnt <= '0;
        tx_valid <= 1'b1;
      end else if (tx_valid) begin
        sh <= sh >> 1;
        cnt <= last ? '0 : cnt + 1'b1;
        tx_valid <= !last;
      end
    end
  end
endmodule

// File: rtl/tag_mem_seq.sv
// tag_mem_seq: arbitrates ADC logging and reader commands onto the shared SRAM, streams reads serially.
// Optional TAG_MEM_TIMESTAMP_EN prefixes stored sensor words with a wrapping sample timestamp.
module tag_mem_seq
  import tag_mem_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int NUM_SENSORS = 2,
  parameter int TS_W        = 8,
  parameter int CH_W        = ch_w(NUM_SENSORS)
) (
  input  logic                   data_clk,
  input  logic                   factory_reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CH_W-1:0]        cmd_chan,
  input  logic [ADDR_W-1:0]      cmd_ptr,
  input  logic [ADDR_W:0]        cmd_words,
  input  logic [WORD_W-1:0]      cmd_wdata,
  output logic                   cmd_err,
  input  logic                   adc_valid,
  output logic                   adc_ready,
  input  logic [CH_W-1:0]        adc_chan,
  input  logic [WORD_W-1:0]      adc_data,
  output logic [NUM_SENSORS:0]   mem_sel,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [WORD_W-1:0]      mem_data_out,
  input  logic [WORD_W-1:0]      mem_read_in,
  output logic                   PC_B,
  output logic                   WE,
  output logic                   SE,
  output logic                   mem_done,
  output logic                   tx_bit,
  output logic                   tx_valid,
  output logic                   tx_data_done,
  output logic [NUM_SENSORS-1:0] log_overflow
);
  localparam logic [CH_W:0] NS = NUM_SENSORS[CH_W:0];
  if (TS_W >= WORD_W || NUM_SENSORS < 1 || NUM_SENSORS > 7) begin : g_param_check
    $error("tag_mem_seq: unsupported parameter set");
  end
  state_t state;
  logic idle_q, is_wr, is_sens;
  logic [CH_W-1:0] rd_chan;
  logic [NUM_SENSORS:0] rd_sel, rd_sel_n;
  logic [ADDR_W-1:0] nxt_addr, rd_start, first_next, step_addr;
  logic [ADDR_W:0] remain, rd_len;
  logic [ADDR_W+1:0] span;
  logic [ADDR_W-1:0] wr_ptr [NUM_SENSORS];
  logic [ADDR_W:0] cnt [NUM_SENSORS];
  logic [WORD_W-1:0] sample_word;
  logic adc_ok, adc_fire, cmd_fire, cmd_bad, sh_empty, sh_last, sh_load;
  op_t op;
  assign op = op_t'(cmd_op);
  assign adc_ready = idle_q;
  assign cmd_ready = idle_q && !adc_valid;
  assign adc_fire = adc_valid && adc_ready;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign adc_ok = {1'b0, adc_chan} < NS;
  assign span = {2'b0, cmd_ptr} + {1'b0, cmd_words};
  assign cmd_bad = op == OP_RSV || (op == OP_SENSOR_READ ? !({1'b0, cmd_chan} < NS)
                                                         : span > (ADDR_W+2)'(2**ADDR_W));
  assign rd_len = op == OP_SENSOR_READ ? cnt[cmd_chan] : cmd_words;
  assign rd_start = op == OP_SENSOR_READ ? wr_ptr[cmd_chan] - 1'b1 : cmd_ptr;
  assign first_next = op == OP_SENSOR_READ ? rd_start - 1'b1 : rd_start + 1'b1;
  assign rd_sel_n = op == OP_SENSOR_READ ? (NUM_SENSORS+1)'(2) << cmd_chan : (NUM_SENSORS+1)'(1);
  assign step_addr = is_sens ? nxt_addr - 1'b1 : nxt_addr + 1'b1;
  assign sh_load = state == S_ACC && !is_wr;
`ifdef TAG_MEM_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge data_clk or posedge factory_reset) begin
    if (factory_reset) ts <= '0;
    else if (adc_fire && adc_ok) ts <= ts + 1'b1;
  end
  assign sample_word = {ts, adc_data[WORD_W-TS_W-1:0]};
`else
  assign sample_word = adc_data;
`endif
  tag_tx_shifter #(.WORD_W(WORD_W)) u_tx (
    .data_clk     (data_clk),
    .factory_reset(factory_reset),
    .load         (sh_load),
    .load_data    (mem_read_in),
    .empty        (sh_empty),
    .last         (sh_last),
    .tx_bit       (tx_bit),
    .tx_valid     (tx_valid)
  );
  always_ff @(posedge data_clk or posedge factory_reset) begin
    if (factory_reset) begin
      state <= S_IDLE;
      idle_q <= 1'b1;
      is_wr <= 1'b0;
      is_sens <= 1'b0;
      rd_chan <= '0;
      rd_sel <= '0;
      nxt_addr <= '0;
      remain <= '0;
      mem_sel <= '0;
      mem_address <= '0;
      mem_data_out <= '0;
      PC_B <= 1'b1;
      WE <= 1'b0;
      SE <= 1'b0;
      mem_done <= 1'b0;
      cmd_err <= 1'b0;
      tx_data_done <= 1'b0;
      log_overflow <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        wr_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      cmd_err <= 1'b0;
      tx_data_done <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (adc_fire) begin
            if (adc_ok) begin
              state <= S_PRE;
              idle_q <= 1'b0;
              PC_B <= 1'b0;
              is_wr <= 1'b1;
              is_sens <= 1'b0;
              mem_sel <= (NUM_SENSORS+1)'(2) << adc_chan;
              mem_address <= wr_ptr[adc_chan];
              mem_data_out <= sample_word;
              wr_ptr[adc_chan] <= wr_ptr[adc_chan] + 1'b1;
              if (cnt[adc_chan][ADDR_W]) log_overflow[adc_chan] <= 1'b1;
              else cnt[adc_chan] <= cnt[adc_chan] + 1'b1;
            end
          end else if (cmd_fire) begin
            if (cmd_bad) cmd_err <= 1'b1;
            else if (op == OP_EPC_WRITE) begin
              state <= S_PRE;
              idle_q <= 1'b0;
              PC_B <= 1'b0;
              is_wr <= 1'b1;
              is_sens <= 1'b0;
              mem_sel <= (NUM_SENSORS+1)'(1);
              mem_address <= cmd_ptr;
              mem_data_out <= cmd_wdata;
            end else if (~|rd_len) tx_data_done <= 1'b1;
            else begin
              state <= S_PRE;
              idle_q <= 1'b0;
              PC_B <= 1'b0;
              is_wr <= 1'b0;
              is_sens <= op == OP_SENSOR_READ;
              rd_chan <= cmd_chan;
              rd_sel <= rd_sel_n;
              mem_sel <= rd_sel_n;
              mem_address <= rd_start;
              nxt_addr <= first_next;
              remain <= rd_len - 1'b1;
            end
          end
        end
        S_PRE: begin
          state <= S_ACC;
          PC_B <= 1'b1;
          WE <= is_wr;
          SE <= !is_wr;
        end
        S_ACC: begin
          state <= S_REL;
          WE <= 1'b0;
          SE <= 1'b0;
          mem_done <= is_wr;
        end
        S_REL: begin
          state <= is_wr ? S_IDLE : S_STREAM;
          idle_q <= is_wr;
          mem_sel <= '0;
        end
        S_STREAM: begin
          if (sh_empty && |remain) begin
            state <= S_PRE;
            PC_B <= 1'b0;
            mem_sel <= rd_sel;
            mem_address <= nxt_addr;
            nxt_addr <= step_addr;
            remain <= remain - 1'b1;
          end else if (sh_empty && sh_last && ~|remain) begin
            state <= S_IDLE;
            idle_q <= 1'b1;
            tx_data_done <= 1'b1;
            if (is_sens) begin
              cnt[rd_chan] <= '0;
              log_overflow[rd_chan] <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tag_mem_seq.sv
// tb_tag_mem_seq: scoreboard bench for tag_mem_seq with a behavioural SRAM model.
module tb_tag_mem_seq;
  import tag_mem_pkg::*;
  localparam int WORD_W = 16, ADDR_W = 6, NUM_SENSORS = 2, TS_W = 8, CH_W = 1, NB = NUM_SENSORS + 1;
  logic data_clk = 1'b0, factory_reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_err;
  logic [1:0] cmd_op = 2'b00;
  logic [CH_W-1:0] cmd_chan = '0;
  logic [ADDR_W-1:0] cmd_ptr = '0;
  logic [ADDR_W:0] cmd_words = '0;
  logic [WORD_W-1:0] cmd_wdata = '0;
  logic adc_valid = 1'b0, adc_ready;
  logic [CH_W-1:0] adc_chan = '0;
  logic [WORD_W-1:0] adc_data = '0;
  logic [NB-1:0] mem_sel;
  logic [ADDR_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_data_out, mem_read_in;
  logic PC_B, WE, SE, mem_done, tx_bit, tx_valid, tx_data_done;
  logic [NUM_SENSORS-1:0] log_overflow;
  int checks = 0, failures = 0, ts_m = 0;
  logic [WORD_W-1:0] exp_q[$];
  int len_q[$];
  logic [WORD_W-1:0] sent1[$];
  logic [WORD_W-1:0] mem [NB][2**ADDR_W];
  logic [WORD_W-1:0] rx, exp_w;
  int bitn = 0, run = 0, exp_len = 0;

  always #5 data_clk = ~data_clk;

  tag_mem_seq #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .NUM_SENSORS(NUM_SENSORS), .TS_W(TS_W)) dut (
    .data_clk(data_clk), .factory_reset(factory_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_chan(cmd_chan),
    .cmd_ptr(cmd_ptr), .cmd_words(cmd_words), .cmd_wdata(cmd_wdata), .cmd_err(cmd_err),
    .adc_valid(adc_valid), .adc_ready(adc_ready), .adc_chan(adc_chan), .adc_data(adc_data),
    .mem_sel(mem_sel), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_read_in(mem_read_in), .PC_B(PC_B), .WE(WE), .SE(SE), .mem_done(mem_done),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_data_done(tx_data_done), .log_overflow(log_overflow)
  );

  always @(posedge data_clk)
    for (int b = 0; b < NB; b++) if (WE && mem_sel[b]) mem[b][mem_address] <= mem_data_out;
  always_comb begin
    mem_read_in = '0;
    for (int b = 0; b < NB; b++) if (SE && mem_sel[b]) mem_read_in = mem[b][mem_address];
  end

  // Deserialises tx words against exp_q; on tx_data_done the run of valid bits just ended must match len_q.
  always @(negedge data_clk) begin
    if (factory_reset) begin
      bitn = 0;
      run = 0;
    end else if (tx_valid) begin
      rx = {tx_bit, rx[WORD_W-1:1]};
      bitn++;
      run++;
      if (bitn == WORD_W) begin
        bitn = 0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_word unexpected got=%h", rx);
        end else begin
          exp_w = exp_q.pop_front();
          if (rx !== exp_w) begin
            failures++;
            $display("FAIL tx_word got=%h want=%h", rx, exp_w);
          end
        end
      end
    end else begin
      if (tx_data_done) begin
        checks++;
        if (len_q.size() == 0) begin
          failures++;
          $display("FAIL tx_done unexpected run=%0d", run);
        end else begin
          exp_len = len_q.pop_front();
          if (run !== exp_len) begin
            failures++;
            $display("FAIL tx_run got=%0d want=%0d", run, exp_len);
          end
        end
      end
      run = 0;
    end
  end

  function automatic logic [WORD_W-1:0] model_word(input logic [WORD_W-1:0] d);
    logic [WORD_W-1:0] w;
`ifdef TAG_MEM_TIMESTAMP_EN
    w = {TS_W'(ts_m), d[WORD_W-TS_W-1:0]};
`else
    w = d;
`endif
    ts_m++;
    return w;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input int chan, input int ptr, input int words,
                          input logic [WORD_W-1:0] wd);
    int n = 0;
    @(negedge data_clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_chan = CH_W'(chan);
    cmd_ptr = ADDR_W'(ptr);
    cmd_words = (ADDR_W+1)'(words);
    cmd_wdata = wd;
    #1;
    while (!cmd_ready && n < 100) begin
      @(negedge data_clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept timeout got=0 want=1");
    end
    @(posedge data_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_adc(input int chan, input logic [WORD_W-1:0] d, output logic [WORD_W-1:0] w);
    int n = 0;
    @(negedge data_clk);
    adc_valid = 1'b1;
    adc_chan = CH_W'(chan);
    adc_data = d;
    while (!adc_ready && n < 100) begin
      @(negedge data_clk);
      n++;
    end
    if (!adc_ready) begin
      checks++;
      failures++;
      $display("FAIL adc_accept timeout got=0 want=1");
    end
    w = model_word(d);
    @(posedge data_clk);
    #1 adc_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge data_clk);
      if (tx_data_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    factory_reset = 1'b1;
    repeat (2) @(negedge data_clk);
    checks++;
    if ({PC_B, cmd_ready, adc_ready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_high got=%b want=111", {PC_B, cmd_ready, adc_ready});
    end
    checks++;
    if ({WE, SE, tx_valid, tx_bit, mem_done, tx_data_done, cmd_err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_low got=%b want=0000000", {WE, SE, tx_valid, tx_bit, mem_done, tx_data_done, cmd_err});
    end
    checks++;
    if ({mem_sel, mem_address, log_overflow} !== '0) begin
      failures++;
      $display("FAIL reset_bus got=%h want=0", {mem_sel, mem_address, log_overflow});
    end
    factory_reset = 1'b0;
  endtask

  task automatic test_epc_write_read();
    int cyc;
    send_cmd(OP_EPC_WRITE, 0, 3, 1, 16'hA5C3);
    @(negedge data_clk);
    checks++;
    if ({PC_B, mem_sel, mem_address, cmd_ready} !== {1'b0, 3'b001, 6'd3, 1'b0}) begin
      failures++;
      $display("FAIL wr_pre got=%h want=%h", {PC_B, mem_sel, mem_address, cmd_ready}, {1'b0, 3'b001, 6'd3, 1'b0});
    end
    @(negedge data_clk);
    checks++;
    if ({PC_B, WE, SE, mem_data_out} !== {3'b110, 16'hA5C3}) begin
      failures++;
      $display("FAIL wr_acc got=%h want=%h", {PC_B, WE, SE, mem_data_out}, {3'b110, 16'hA5C3});
    end
    @(negedge data_clk);
    checks++;
    if ({WE, mem_done} !== 2'b01) begin
      failures++;
      $display("FAIL wr_rel got=%b want=01", {WE, mem_done});
    end
    @(negedge data_clk);
    checks++;
    if ({cmd_ready, mem_done} !== 2'b10) begin
      failures++;
      $display("FAIL wr_idle got=%b want=10", {cmd_ready, mem_done});
    end
    exp_q.push_back(16'hA5C3);
    len_q.push_back(WORD_W);
    send_cmd(OP_EPC_READ, 0, 3, 1, '0);
    @(negedge data_clk);
    @(negedge data_clk);
    checks++;
    if ({PC_B, SE} !== 2'b11) begin
      failures++;
      $display("FAIL rd_acc got=%b want=11", {PC_B, SE});
    end
    @(negedge data_clk);
    @(negedge data_clk);
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL rd_first_valid got=%b want=1", tx_valid);
    end
    wait_done(60, cyc);
    checks++;
    if (cyc !== WORD_W || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_done_time got=%0d/%b want=%0d/1", cyc, cmd_ready, WORD_W);
    end
  endtask

  task automatic test_sensor_overflow();
    logic [WORD_W-1:0] w;
    int cyc;
    sent1.delete();
    for (int i = 0; i < 70; i++) begin
      send_adc(1, WORD_W'(i), w);
      sent1.push_back(w);
    end
    repeat (4) @(negedge data_clk);
    checks++;
    if (log_overflow !== 2'b10) begin
      failures++;
      $display("FAIL ovf_set got=%b want=10", log_overflow);
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(sent1[69 - i]);
    len_q.push_back(64 * WORD_W);
    send_cmd(OP_SENSOR_READ, 1, 0, 0, '0);
    wait_done(64 * WORD_W + 300, cyc);
    checks++;
    if (cyc < 0 || log_overflow !== 2'b00) begin
      failures++;
      $display("FAIL ovf_read got=%0d/%b want=done/00", cyc, log_overflow);
    end
    len_q.push_back(0);
    send_cmd(OP_SENSOR_READ, 1, 0, 0, '0);
    @(negedge data_clk);
    checks++;
    if ({tx_data_done, PC_B, cmd_ready} !== 3'b111) begin
      failures++;
      $display("FAIL count_clear got=%b want=111", {tx_data_done, PC_B, cmd_ready});
    end
  endtask

  task automatic test_arbitration();
    logic [WORD_W-1:0] w0;
    int n = 0, cyc;
    logic sel_ok = 1'b0;
    @(negedge data_clk);
    adc_valid = 1'b1;
    adc_chan = 1'b0;
    adc_data = 16'h1234;
    cmd_valid = 1'b1;
    cmd_op = OP_EPC_READ;
    cmd_chan = '0;
    cmd_ptr = 6'd3;
    cmd_words = 7'd1;
    #1;
    checks++;
    if ({cmd_ready, adc_ready} !== 2'b01) begin
      failures++;
      $display("FAIL arb_ready got=%b want=01", {cmd_ready, adc_ready});
    end
    w0 = model_word(16'h1234);
    @(posedge data_clk);
    #1 adc_valid = 1'b0;
    while (n < 20) begin
      @(negedge data_clk);
      #1;
      n++;
      if (n == 1) sel_ok = mem_sel === 3'b010 && PC_B === 1'b0;
      if (cmd_ready) break;
    end
    checks++;
    if (n !== 4 || !sel_ok) begin
      failures++;
      $display("FAIL arb_order got=%0d/%b want=4/1", n, sel_ok);
    end
    exp_q.push_back(16'hA5C3);
    len_q.push_back(WORD_W);
    @(posedge data_clk);
    #1 cmd_valid = 1'b0;
    wait_done(60, cyc);
    exp_q.push_back(w0);
    len_q.push_back(WORD_W);
    send_cmd(OP_SENSOR_READ, 0, 0, 0, '0);
    wait_done(60, cyc);
    checks++;
    if (cyc !== WORD_W + 4) begin
      failures++;
      $display("FAIL sens0_time got=%0d want=%0d", cyc, WORD_W + 4);
    end
  endtask

  task automatic test_errors();
    logic pcb_low = 1'b0, err_again = 1'b0;
    send_cmd(OP_EPC_READ, 0, 60, 8, '0);
    @(negedge data_clk);
    checks++;
    if (cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL err_span got=%b want=1", cmd_err);
    end
    repeat (4) begin
      @(negedge data_clk);
      pcb_low |= !PC_B;
      err_again |= cmd_err;
    end
    checks++;
    if ({pcb_low, err_again} !== 2'b00) begin
      failures++;
      $display("FAIL err_quiet got=%b want=00", {pcb_low, err_again});
    end
    send_cmd(OP_RSV, 0, 0, 1, '0);
    @(negedge data_clk);
    checks++;
    if (cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL err_op got=%b want=1", cmd_err);
    end
    len_q.push_back(0);
    send_cmd(OP_EPC_READ, 0, 5, 0, '0);
    @(negedge data_clk);
    checks++;
    if ({tx_data_done, cmd_err, PC_B, cmd_ready} !== 4'b1011) begin
      failures++;
      $display("FAIL zero_len got=%b want=1011", {tx_data_done, cmd_err, PC_B, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 4; i++) send_cmd(OP_EPC_WRITE, 0, 60 + i, 1, 16'hC000 + 16'(i * 16'h111));
    for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i * 16'h111));
    len_q.push_back(4 * WORD_W);
    send_cmd(OP_EPC_READ, 0, 60, 4, '0);
    wait_done(200, cyc);
    checks++;
    if (cyc !== 4 * WORD_W + 4) begin
      failures++;
      $display("FAIL b2b_time got=%0d want=%0d", cyc, 4 * WORD_W + 4);
    end
  endtask

  task automatic test_reset_abort();
    logic [WORD_W-1:0] w;
    logic pulse = 1'b0;
    int n = 0;
    send_adc(0, 16'h7777, w);
    repeat (4) @(negedge data_clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i * 16'h111));
    len_q.push_back(4 * WORD_W);
    send_cmd(OP_EPC_READ, 0, 60, 4, '0);
    while (!tx_valid && n < 20) begin
      @(negedge data_clk);
      n++;
    end
    repeat (20) @(negedge data_clk);
    #2 factory_reset = 1'b1;
    #1;
    checks++;
    if ({PC_B, WE, SE, tx_valid, cmd_ready, adc_ready} !== 6'b100011) begin
      failures++;
      $display("FAIL abort_out got=%b want=100011", {PC_B, WE, SE, tx_valid, cmd_ready, adc_ready});
    end
    repeat (2) begin
      @(negedge data_clk);
      pulse |= tx_data_done | mem_done;
    end
    exp_q.delete();
    len_q.delete();
    ts_m = 0;
    factory_reset = 1'b0;
    @(negedge data_clk);
    pulse |= tx_data_done | mem_done;
    checks++;
    if (pulse !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse got=%b want=0", pulse);
    end
    len_q.push_back(0);
    send_cmd(OP_SENSOR_READ, 0, 0, 0, '0);
    @(negedge data_clk);
    checks++;
    if ({tx_data_done, PC_B, log_overflow} !== 4'b1100) begin
      failures++;
      $display("FAIL abort_empty got=%b want=1100", {tx_data_done, PC_B, log_overflow});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_epc_write_read();
    test_sensor_overflow();
    test_arbitration();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge data_clk);
    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d/%0d want=0/0", exp_q.size(), len_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tag_mem_seq.md
# tag_mem_seq

Parametrised tag memory sequencer that replaces the fixed two-sensor memory interface. It arbitrates ADC sample logging and reader commands onto the shared SRAM macro through the PC_B/WE/SE precharge protocol. Sensor banks are NUM_SENSORS independent circular logs with overflow tracking. Read data is streamed as a gap-free serial bit stream to the tag modulator through a one-word prefetch buffer.

## Interface
Parameters:
- WORD_W, 16, memory word width (≥8)
- ADDR_W, 6, word address width; each bank holds 2**ADDR_W words
- NUM_SENSORS, 2, sensor log banks (1..7)
- TS_W, 8, timestamp field width (< WORD_W)

Ports:
- data_clk  in  1  clock
- factory_reset  in  1  reset, asynchronous, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_op  in  2  00 EPC_READ, 01 EPC_WRITE, 10 SENSOR_READ, 11 reserved
- cmd_chan  in  CH_W=max(1,$clog2(NUM_SENSORS))  sensor bank for SENSOR_READ
- cmd_ptr  in  ADDR_W  EPC start address
- cmd_words  in  ADDR_W+1  EPC word count
- cmd_wdata  in  WORD_W  EPC write data
- cmd_err  out  1  one-cycle pulse, command rejected
- adc_valid / adc_ready  in / out  1  sample handshake
- adc_chan  in  CH_W  sample bank
- adc_data  in  WORD_W  sample payload
- mem_sel  out  NUM_SENSORS+1  one-hot bank select; bit0 EPC, bit k sensor k-1
- mem_address  out  ADDR_W  word line
- mem_data_out / mem_read_in  out / in  WORD_W  write / read data
- PC_B, WE, SE  out  1  precharge (active low), write enable, sense enable
- mem_done  out  1  one-cycle pulse per completed write
- tx_bit, tx_valid  out  1  serial data, LSB first, qualified by tx_valid
- tx_data_done  out  1  one-cycle pulse after last bit of a read
- log_overflow  out  NUM_SENSORS  sticky per-bank overflow

## Operation
- Reset values: PC_B=1, cmd_ready=1, adc_ready=1; every other output 0. All log pointers/counts, timestamp and FSM are cleared.
- Main FSM states: IDLE, PRE, ACC, REL, STREAM.
- Access sequence:
  - PRE: PC_B=0; mem_sel and mem_address driven.
  - ACC: PC_B=1; WE=1 (write) or SE=1 (read). Read data is captured at the end of ACC.
  - REL: WE=SE=0; mem_sel and mem_address hold.
- Acceptance: only in IDLE. adc beats cmd when both are valid; the command waits. cmd_ready and adc_ready are low outside IDLE.
- Error: cmd_op=11, cmd_chan≥NUM_SENSORS or cmd_ptr+cmd_words>2**ADDR_W → handshake completes, cmd_err pulses, no memory access.
- Invalid ADC bank: adc_chan≥NUM_SENSORS → sample accepted and dropped.
- Sensor write:
  - Target address is wr_ptr[c].
  - wr_ptr wraps modulo 2**ADDR_W.
  - count[c] saturates at 2**ADDR_W.
  - A write at full overwrites the oldest entry and sets log_overflow[c].
- EPC write: cmd_wdata is written to cmd_ptr in bank 0.
- EPC read: cmd_words words, ascending from cmd_ptr.
- SENSOR_READ:
  - Streams count[c] words, newest first (wr_ptr-1 downward, wrapping).
  - On completion, count[c] and log_overflow[c] clear.
  - wr_ptr is unchanged.
- Zero-length read (cmd_words=0 or count=0): no access; tx_data_done pulses the cycle after acceptance.
- Streaming:
  - The shifter loads from the prefetch buffer when its last bit goes out.
  - A new fetch starts whenever the buffer is empty and words remain.
  - The 3-cycle fetch is shorter than WORD_W, so tx_valid never drops mid-read.

## Timing
- Accept at cycle T → PRE T+1, ACC T+2, REL T+3, IDLE T+4 (ready high).
- Writes: mem_done pulses at T+3; 4-cycle occupancy.
- Reads:
  - First tx_valid at T+4.
  - Exactly N·WORD_W consecutive valid cycles.
  - tx_data_done in the first cycle after the last bit; IDLE the same cycle.
- factory_reset mid-operation aborts immediately:
  - PC_B=1, WE=SE=0, tx_valid=0.
  - No tx_data_done or mem_done.
  - Logs are empty after reset.

## Configuration
- TAG_MEM_TIMESTAMP_EN defined:
  - Stored sensor word = {ts[TS_W-1:0], adc_data[WORD_W-TS_W-1:0]}.
  - ts is a global counter that increments per accepted valid sample and wraps.
- TAG_MEM_TIMESTAMP_EN undefined: stored word = adc_data; no ts counter is present.

## Structure
- Package tag_mem_pkg: cmd_op encodings, FSM state enum, CH_W helper function.
- Sub-module tag_tx_shifter:
  - One-word prefetch buffer plus bit shifter.
  - Interface: load/valid/empty handshake with the FSM; drives tx_bit, tx_valid.
- Per-bank wr_ptr/count/overflow live in the top as arrays sized NUM_SENSORS.

## Test plan
- EPC_WRITE ptr=3 data=16'hA5C3, then EPC_READ ptr=3 words=1 → PC_B low at T+1, WE at T+2; read gives 16 tx bits LSB first equal to A5C3, then tx_data_done.
- 70 samples 0..69 to chan 1 (ADDR_W=6), then SENSOR_READ chan 1 → log_overflow[1]=1 before the read; 64 words streamed, 69 down to 6; overflow and count clear after.
- adc_valid and cmd_valid asserted in the same IDLE cycle → sample accepted first; command accepted at T+4.
- EPC_READ ptr=60 words=8 → cmd_err pulse, no PC_B activity. cmd_words=0 → tx_data_done the cycle after accept.
- EPC_READ words=4 → 64 contiguous tx_valid cycles, no gaps.
- factory_reset asserted during a read → outputs at reset values that cycle; a subsequent SENSOR_READ gives immediate tx_data_done (empty log).
